// File: rtl/rx_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_fifo
// Function : Receive frame FIFO. Words become visible only once the whole
//            frame has been committed. Overflowed frames are rolled back.
//            Define RXFIFO_BAD_DROP_EN to also roll back bad frames; without
//            it, bad frames are delivered with an error flag on the last word.
// Revision : 1.0
// ============================================================================
module rx_frame_fifo #(
   parameter int DEPTH_LOG2 = 9
) (
   input  logic        rxclk_in,
   input  logic        reset_out,
   input  logic [63:0] rx_data,
   input  logic [7:0]  rx_data_valid,
   input  logic        rx_good_frame,
   input  logic        rx_bad_frame,
   output logic [63:0] fifo_rd_data,
   output logic [7:0]  fifo_rd_keep,
   output logic        fifo_rd_last,
   output logic        fifo_rd_err,
   output logic        fifo_rd_valid,
   input  logic        fifo_rd_ready,
   output logic        fifo_frame_dropped,
   output logic        fifo_overflow,
   output logic [15:0] fifo_drop_cnt
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int WORD_W = 74;   // {err, last, keep[7:0], data[63:0]}
`ifdef RXFIFO_BAD_DROP_EN
   localparam logic DROP_BAD = 1'b1;
`else
   localparam logic DROP_BAD = 1'b0;
`endif

   logic [WORD_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr_inc;
   logic [DEPTH_LOG2-1:0] wr_commit;
   logic [DEPTH_LOG2-1:0] rd_ptr;

   logic                  pend_valid;
   logic [63:0]           pend_data;
   logic [7:0]            pend_keep;
   logic                  frame_ovf;
   logic                  frame_active;

   logic                  beat;
   logic                  status;
   logic                  full;
   logic                  close;
   logic                  close_ovf;
   logic                  commit;
   logic                  discard;
   logic                  mem_we;
   logic [WORD_W-1:0]     mem_wdata;

   logic [WORD_W-1:0]     stage_word;
   logic                  stage_valid;
   logic [WORD_W-1:0]     out_word;
   logic                  out_valid;
   logic                  avail;
   logic                  take;
   logic                  move;
   logic                  fetch;

   assign wr_ptr_inc = wr_ptr + 1'b1;

   // The pending beat is only flushed to memory once we know whether it is
   // the last one, so the last flag can be written together with the data.
   always_comb begin
      beat      = |rx_data_valid;
      status    = rx_good_frame | rx_bad_frame;
      full      = (wr_ptr_inc == rd_ptr);
      close     = status & frame_active;
      close_ovf = frame_ovf | full;
      commit    = close & ~close_ovf & ~(rx_bad_frame & DROP_BAD);
      discard   = close & ~commit;
      mem_we    = 1'b0;
      mem_wdata = {1'b0, 1'b0, pend_keep, pend_data};
      if (close && !close_ovf) begin
         mem_we    = 1'b1;
         mem_wdata = {rx_bad_frame & ~DROP_BAD, 1'b1, pend_keep, pend_data};
      end else if (beat && pend_valid && !frame_ovf && !full) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge rxclk_in or posedge reset_out) begin
      if (reset_out) begin
         wr_ptr             <= '0;
         wr_commit          <= '0;
         pend_valid         <= 1'b0;
         pend_data          <= '0;
         pend_keep          <= '0;
         frame_ovf          <= 1'b0;
         frame_active       <= 1'b0;
         fifo_frame_dropped <= 1'b0;
         fifo_overflow      <= 1'b0;
         fifo_drop_cnt      <= '0;
      end else begin
         fifo_frame_dropped <= 1'b0;
         fifo_overflow      <= 1'b0;
         if (mem_we) begin
            wr_ptr <= wr_ptr_inc;
         end
         if (beat && !frame_ovf) begin
            frame_active <= 1'b1;
            if (pend_valid && full) begin
               frame_ovf  <= 1'b1;
               pend_valid <= 1'b0;
            end else begin
               pend_valid <= 1'b1;
               pend_data  <= rx_data;
               pend_keep  <= rx_data_valid;
            end
         end
         if (close) begin
            frame_active <= 1'b0;
            frame_ovf    <= 1'b0;
            pend_valid   <= 1'b0;
            if (commit) begin
               wr_commit <= wr_ptr_inc;
            end
            // Rollback overrides the increment of the final word write.
            if (discard) begin
               wr_ptr             <= wr_commit;
               fifo_frame_dropped <= 1'b1;
               fifo_overflow      <= close_ovf;
               if (fifo_drop_cnt != 16'hFFFF) begin
                  fifo_drop_cnt <= fifo_drop_cnt + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge rxclk_in) begin
      if (mem_we) begin
         mem[wr_ptr] <= mem_wdata;
      end
      if (fetch) begin
         stage_word <= mem[rd_ptr];
      end
   end

   // Two-stage read pipe: a fetch is issued whenever the staging register
   // will be free after this edge, which keeps one word per cycle flowing.
   always_comb begin
      avail = (rd_ptr != wr_commit);
      take  = out_valid & fifo_rd_ready;
      move  = stage_valid & (~out_valid | take);
      fetch = avail & (~stage_valid | move);
   end

   always_ff @(posedge rxclk_in or posedge reset_out) begin
      if (reset_out) begin
         rd_ptr      <= '0;
         stage_valid <= 1'b0;
         out_valid   <= 1'b0;
         out_word    <= '0;
      end else begin
         if (fetch) begin
            rd_ptr      <= rd_ptr + 1'b1;
            stage_valid <= 1'b1;
         end else if (move) begin
            stage_valid <= 1'b0;
         end
         if (move) begin
            out_valid <= 1'b1;
            out_word  <= stage_word;
         end else if (take) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign fifo_rd_data  = out_word[63:0];
   assign fifo_rd_keep  = out_word[71:64];
   assign fifo_rd_last  = out_word[72];
   assign fifo_rd_err   = out_word[73] & ~DROP_BAD;
   assign fifo_rd_valid = out_valid;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// Frame-level reference model: committed frames become expected words in a
// queue, discarded frames become expected drop/overflow pulse counts.
module tb_rx_frame_fifo;
   localparam int DL2 = 4;
   localparam int CAP = (1 << DL2) - 1;
`ifdef RXFIFO_BAD_DROP_EN
   localparam bit DROP_BAD = 1'b1;
`else
   localparam bit DROP_BAD = 1'b0;
`endif

   typedef logic [73:0] word_t;   // {err, last, keep, data}

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] rx_data = '0;
   logic [7:0]  rx_keep = '0;
   logic        good = 1'b0;
   logic        bad = 1'b0;
   logic        ready = 1'b0;
   logic [63:0] rd_data;
   logic [7:0]  rd_keep;
   logic        rd_last;
   logic        rd_err;
   logic        rd_valid;
   logic        dropped;
   logic        ovf;
   logic [15:0] drop_cnt;
   word_t       cur_w;

   word_t exp_q[$];
   word_t got_q[$];
   int    n_checks = 0;
   int    n_pass = 0;
   int    drop_pulses = 0;
   int    ovf_pulses = 0;
   int    ovf_alone = 0;
   int    stall_viol = 0;
   int    exp_drops = 0;
   int    exp_ovfs = 0;
   int    exp_drop_cnt = 0;
   int    ready_mode = 1;   // 0 high, 1 low, 2 toggle, 3 random
   bit    held = 1'b0;
   word_t held_w = '0;

   always #5 clk = ~clk;

   assign cur_w = {rd_err, rd_last, rd_keep, rd_data};

   rx_frame_fifo #(.DEPTH_LOG2(DL2)) dut (
      .rxclk_in          (clk),
      .reset_out         (rst),
      .rx_data           (rx_data),
      .rx_data_valid     (rx_keep),
      .rx_good_frame     (good),
      .rx_bad_frame      (bad),
      .fifo_rd_data      (rd_data),
      .fifo_rd_keep      (rd_keep),
      .fifo_rd_last      (rd_last),
      .fifo_rd_err       (rd_err),
      .fifo_rd_valid     (rd_valid),
      .fifo_rd_ready     (ready),
      .fifo_frame_dropped(dropped),
      .fifo_overflow     (ovf),
      .fifo_drop_cnt     (drop_cnt)
   );

   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       ready = 1'b1;
         1:       ready = 1'b0;
         2:       ready = ~ready;
         default: ready = 1'($urandom_range(0, 1));
      endcase
   end

   initial forever begin
      @(negedge clk);
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held && (!rd_valid || cur_w !== held_w)) stall_viol++;
         if (rd_valid && ready) got_q.push_back(cur_w);
         held   = rd_valid && !ready;
         held_w = cur_w;
         if (dropped) drop_pulses++;
         if (ovf) ovf_pulses++;
         if (ovf && !dropped) ovf_alone++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic g, input logic b);
      @(posedge clk);
      #1;
      rx_data = d;
      rx_keep = k;
      good    = g;
      bad     = b;
   endtask

   task automatic send_frame(input int nb, input logic g, input logic b, input logic [7:0] last_keep,
                             input int max_gap, input bit exp_ovf);
      word_t       w[$];
      logic [63:0] d;
      logic [7:0]  k;
      logic        lst;
      for (int i = 0; i < nb; i++) begin
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) drive('0, '0, 1'b0, 1'b0);
         d   = {$urandom, $urandom};
         lst = (i == nb - 1);
         k   = lst ? last_keep : 8'hFF;
         drive(d, k, 1'b0, 1'b0);
         w.push_back({lst & b, lst, k, d});
      end
      drive('0, '0, g, b);
      if (nb == 0) begin
         // a lone status pulse closes nothing
      end else if (exp_ovf) begin
         exp_drops++;
         exp_ovfs++;
         exp_drop_cnt++;
      end else if (b && DROP_BAD) begin
         exp_drops++;
         exp_drop_cnt++;
      end else begin
         foreach (w[i]) exp_q.push_back(w[i]);
      end
   endtask

   task automatic drain(input int budget, output bit timeout);
      int n = 0;
      while (got_q.size() < exp_q.size() && n < budget) begin
         drive('0, '0, 1'b0, 1'b0);
         n++;
      end
      timeout = (got_q.size() < exp_q.size());
      repeat (6) drive('0, '0, 1'b0, 1'b0);
   endtask

   task automatic start_test(input int mode);
      ready_mode = mode;
      got_q.delete();
      exp_q.delete();
      repeat (2) drive('0, '0, 1'b0, 1'b0);
   endtask

   function automatic int first_diff();
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) drive('0, '0, 1'b0, 1'b0);
      n_checks++;
      if ({rd_valid, rd_last, rd_err, dropped, ovf} !== 5'b0)
         $display("FAIL reset_flags got=%b exp=00000", {rd_valid, rd_last, rd_err, dropped, ovf});
      else n_pass++;
      n_checks++;
      if ({rd_data, rd_keep} !== 72'h0) $display("FAIL reset_data got=%h exp=0", {rd_data, rd_keep});
      else n_pass++;
      rst = 1'b0;
      repeat (3) drive('0, '0, 1'b0, 1'b0);
      n_checks++;
      if (rd_valid !== 1'b0 || drop_cnt !== 16'h0)
         $display("FAIL after_reset valid=%b cnt=%h exp valid=0 cnt=0", rd_valid, drop_cnt);
      else n_pass++;
   endtask

   task automatic test_good_frame();
      bit to;
      int d;
      start_test(0);
      send_frame(10, 1'b1, 1'b0, 8'h0F, 0, 1'b0);
      drain(200, to);
      n_checks++;
      if (to || got_q.size() != 10) $display("FAIL good_count got=%0d exp=10", got_q.size());
      else n_pass++;
      d = first_diff();
      n_checks++;
      if (d >= 0) $display("FAIL good_word idx=%0d got=%h exp=%h", d, got_q[d], exp_q[d]);
      else n_pass++;
      n_checks++;
      if (got_q.size() != 10 || got_q[9][72:64] !== 9'h10F)
         $display("FAIL good_last_keep got=%h exp=10f", got_q.size() == 10 ? got_q[9][72:64] : 9'h0);
      else n_pass++;
      n_checks++;
      if (drop_cnt !== 16'(exp_drop_cnt)) $display("FAIL good_drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop_cnt);
      else n_pass++;
   endtask

   task automatic test_bad_frame();
      bit to;
      int d;
      start_test(0);
      send_frame(6, 1'b0, 1'b1, 8'h3F, 0, 1'b0);
      drain(200, to);
      n_checks++;
      if (to || got_q.size() != exp_q.size()) $display("FAIL bad_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      else n_pass++;
      d = first_diff();
      n_checks++;
      if (d >= 0) $display("FAIL bad_word idx=%0d got=%h exp=%h", d, got_q[d], exp_q[d]);
      else n_pass++;
      n_checks++;
      if (drop_pulses != exp_drops) $display("FAIL bad_drop_pulses got=%0d exp=%0d", drop_pulses, exp_drops);
      else n_pass++;
      n_checks++;
      if (drop_cnt !== 16'(exp_drop_cnt)) $display("FAIL bad_drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop_cnt);
      else n_pass++;
   endtask

   task automatic test_status_edge();
      bit to;
      int d;
      start_test(0);
      send_frame(0, 1'b1, 1'b0, 8'hFF, 0, 1'b0);
      send_frame(3, 1'b1, 1'b1, 8'h01, 1, 1'b0);
      send_frame(0, 1'b0, 1'b1, 8'hFF, 0, 1'b0);
      send_frame(2, 1'b1, 1'b0, 8'h03, 0, 1'b0);
      drain(200, to);
      d = first_diff();
      n_checks++;
      if (to || d >= 0 || got_q.size() != exp_q.size())
         $display("FAIL status_words got_n=%0d exp_n=%0d idx=%0d", got_q.size(), exp_q.size(), d);
      else n_pass++;
      n_checks++;
      if (drop_pulses != exp_drops || drop_cnt !== 16'(exp_drop_cnt))
         $display("FAIL status_drops got=%0d/%0d exp=%0d/%0d", drop_pulses, drop_cnt, exp_drops, exp_drop_cnt);
      else n_pass++;
   endtask

   task automatic test_mixed();
      bit to;
      int d;
      int lasts = 0;
      start_test(0);
      send_frame(3, 1'b1, 1'b0, 8'hFF, 0, 1'b0);
      send_frame(4, 1'b0, 1'b1, 8'h07, 0, 1'b0);
      send_frame(2, 1'b1, 1'b0, 8'h1F, 0, 1'b0);
      drain(200, to);
      d = first_diff();
      n_checks++;
      if (to || d >= 0 || got_q.size() != exp_q.size())
         $display("FAIL mixed_words got_n=%0d exp_n=%0d idx=%0d", got_q.size(), exp_q.size(), d);
      else n_pass++;
      foreach (got_q[i]) if (got_q[i][72]) lasts++;
      n_checks++;
      if (lasts != (DROP_BAD ? 2 : 3)) $display("FAIL mixed_lasts got=%0d exp=%0d", lasts, DROP_BAD ? 2 : 3);
      else n_pass++;
   endtask

   task automatic test_toggle_ready();
      bit to;
      int d;
      start_test(2);
      send_frame(8, 1'b1, 1'b0, 8'hFF, 0, 1'b0);
      drain(300, to);
      d = first_diff();
      n_checks++;
      if (to || d >= 0 || got_q.size() != 8)
         $display("FAIL toggle_words got_n=%0d exp_n=8 idx=%0d", got_q.size(), d);
      else n_pass++;
      n_checks++;
      if (stall_viol != 0) $display("FAIL toggle_stall got=%0d exp=0", stall_viol);
      else n_pass++;
   endtask

   task automatic test_latency();
      bit          to;
      int          found = 0;
      logic [63:0] d = {$urandom, $urandom};
      start_test(0);
      drive(d, 8'h07, 1'b0, 1'b0);
      drive('0, '0, 1'b1, 1'b0);
      exp_q.push_back({1'b0, 1'b1, 8'h07, d});
      drive('0, '0, 1'b0, 1'b0);
      for (int n = 1; n <= 4 && found == 0; n++) begin
         @(negedge clk);
         if (rd_valid) found = n;
      end
      n_checks++;
      if (found == 0) $display("FAIL latency got=none exp=<=4 negedges");
      else n_pass++;
      drain(50, to);
      n_checks++;
      if (to || got_q.size() != 1 || first_diff() >= 0)
         $display("FAIL latency_word got_n=%0d exp_n=1", got_q.size());
      else n_pass++;
   endtask

   task automatic test_overflow();
      bit to;
      int d;
      start_test(1);
      send_frame(CAP, 1'b1, 1'b0, 8'hFF, 0, 1'b0);
      repeat (6) drive('0, '0, 1'b0, 1'b0);
      ready_mode = 0;
      drain(200, to);
      d = first_diff();
      n_checks++;
      if (to || d >= 0 || got_q.size() != CAP)
         $display("FAIL full_fit got_n=%0d exp_n=%0d idx=%0d", got_q.size(), CAP, d);
      else n_pass++;
      start_test(1);
      send_frame(20, 1'b1, 1'b0, 8'hFF, 0, 1'b1);
      repeat (8) drive('0, '0, 1'b0, 1'b0);
      n_checks++;
      if (ovf_pulses != exp_ovfs || drop_pulses != exp_drops || ovf_alone != 0)
         $display("FAIL ovf_pulses got=%0d/%0d/%0d exp=%0d/%0d/0", ovf_pulses, drop_pulses, ovf_alone, exp_ovfs, exp_drops);
      else n_pass++;
      n_checks++;
      if (rd_valid !== 1'b0 || got_q.size() != 0) $display("FAIL ovf_readable got=%b exp=0", rd_valid);
      else n_pass++;
      n_checks++;
      if (drop_cnt !== 16'(exp_drop_cnt)) $display("FAIL ovf_drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop_cnt);
      else n_pass++;
      ready_mode = 0;
      send_frame(3, 1'b1, 1'b0, 8'h07, 0, 1'b0);
      drain(200, to);
      d = first_diff();
      n_checks++;
      if (to || d >= 0 || got_q.size() != 3)
         $display("FAIL ovf_next got_n=%0d exp_n=3 idx=%0d", got_q.size(), d);
      else n_pass++;
   endtask

   task automatic test_random();
      bit   to;
      int   d;
      int   guard;
      logic b;
      logic g;
      start_test(3);
      for (int f = 0; f < 40; f++) begin
         guard = 0;
         while (exp_q.size() - got_q.size() > 6 && guard < 300) begin
            drive('0, '0, 1'b0, 1'b0);
            guard++;
         end
         b = ($urandom_range(0, 3) == 0);
         g = !b || ($urandom_range(0, 1) == 1);
         send_frame($urandom_range(0, 6), g, b, 8'hFF >> $urandom_range(0, 7), $urandom_range(0, 2), 1'b0);
      end
      drain(3000, to);
      d = first_diff();
      n_checks++;
      if (to || d >= 0 || got_q.size() != exp_q.size())
         $display("FAIL random_words got_n=%0d exp_n=%0d idx=%0d", got_q.size(), exp_q.size(), d);
      else n_pass++;
      n_checks++;
      if (drop_pulses != exp_drops || drop_cnt !== 16'(exp_drop_cnt))
         $display("FAIL random_drops got=%0d/%0d exp=%0d/%0d", drop_pulses, drop_cnt, exp_drops, exp_drop_cnt);
      else n_pass++;
      n_checks++;
      if (stall_viol != 0) $display("FAIL random_stall got=%0d exp=0", stall_viol);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      bit to;
      int d;
      start_test(1);
      send_frame(3, 1'b1, 1'b0, 8'hFF, 0, 1'b0);
      for (int i = 0; i < 4; i++) drive({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst     = 1'b1;
      rx_keep = '0;
      #1;
      n_checks++;
      if ({rd_valid, rd_last, rd_err, dropped, ovf} !== 5'b0 || {rd_data, rd_keep} !== 72'h0)
         $display("FAIL midreset_outputs got=%b/%h exp=0/0", {rd_valid, rd_last, rd_err, dropped, ovf}, {rd_data, rd_keep});
      else n_pass++;
      n_checks++;
      if (drop_cnt !== 16'h0) $display("FAIL midreset_cnt got=%0d exp=0", drop_cnt);
      else n_pass++;
      repeat (2) drive('0, '0, 1'b0, 1'b0);
      rst = 1'b0;
      exp_drop_cnt = 0;
      start_test(0);
      send_frame(2, 1'b1, 1'b0, 8'h0F, 0, 1'b0);
      send_frame(4, 1'b0, 1'b1, 8'h03, 0, 1'b0);
      drain(200, to);
      d = first_diff();
      n_checks++;
      if (to || d >= 0 || got_q.size() != (DROP_BAD ? 2 : 6))
         $display("FAIL midreset_words got_n=%0d exp_n=%0d idx=%0d", got_q.size(), DROP_BAD ? 2 : 6, d);
      else n_pass++;
      n_checks++;
      if (got_q.size() == 0 || got_q[got_q.size()-1][73] !== !DROP_BAD)
         $display("FAIL midreset_err got=%b exp=%b", got_q.size() == 0 ? 1'bx : got_q[got_q.size()-1][73], !DROP_BAD);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_frame();
      test_status_edge();
      test_mixed();
      test_toggle_ready();
      test_latency();
      test_overflow();
      test_random();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
